// File: rtl/seq_transmitter.sv
// ============================================================================
//  Module   : seq_transmitter
//  Purpose  : Loads an NBITS-wide pattern and a payload length, then shifts
//             pattern[len] down to pattern[0] out on a registered serial line,
//             MSB first.
//             With SEQ_TRANSMITTER_STUFF_EN defined, the frame is bit-stuffed
//             so that "111" can only occur as the closing trailer:
//               - a 0 is inserted after every two consecutive payload 1s
//                 when more payload bits follow,
//               - a 0 pad is sent when the last payload bit was a 1,
//               - the trailer 1,1,1 is sent, and done marks its third bit.
//             Without the macro only the raw payload is sent, and done marks
//             the last payload bit.
//  Ports    : clk     - clock, all state changes on its rising edge
//             reset   - asynchronous active-low reset
//             load    - frame start request, accepted only while busy=0
//             pattern - payload bits, captured on acceptance
//             len     - payload length minus one, captured on acceptance
//             data    - registered serial output, 0 when idle
//             busy    - high while a frame bit is on data
//             done    - one-cycle pulse on the final bit of a frame
//  Macros   : SEQ_TRANSMITTER_STUFF_EN - enables stuffing, padding, trailer
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_transmitter #(
    parameter int NBITS = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic [NBITS-1:0]         pattern,
    input  logic [$clog2(NBITS)-1:0] len,
    output logic                     data,
    output logic                     busy,
    output logic                     done
);

    localparam int c_IW = $clog2(NBITS);

`ifdef SEQ_TRANSMITTER_STUFF_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEND  = 3'd1,
        S_STUFF = 3'd2,
        S_PAD   = 3'd3,
        S_TRAIL = 3'd4
    } state_t;
`else
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;
`endif

    state_t             r_state;
    state_t             w_state_nxt;
    logic [NBITS-1:0]   r_pat;
    logic [NBITS-1:0]   w_pat_nxt;
    // r_idx always names the payload bit most recently put on data
    logic [c_IW-1:0]    r_idx;
    logic [c_IW-1:0]    w_idx_nxt;
    logic [c_IW-1:0]    w_idx_dec;
    logic               r_data;
    logic               w_data_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               r_done;
    logic               w_done_nxt;
`ifdef SEQ_TRANSMITTER_STUFF_EN
    // r_run counts consecutive 1s ending with the bit currently on data
    logic [1:0]         r_run;
    logic [1:0]         w_run_nxt;
    // r_tcnt numbers the trailer bit currently on data (0..2)
    logic [1:0]         r_tcnt;
    logic [1:0]         w_tcnt_nxt;
`endif

    assign w_idx_dec = r_idx - c_IW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_pat   <= '0;
            r_idx   <= '0;
            r_data  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SEQ_TRANSMITTER_STUFF_EN
            r_run   <= 2'd0;
            r_tcnt  <= 2'd0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_pat   <= w_pat_nxt;
            r_idx   <= w_idx_nxt;
            r_data  <= w_data_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
`ifdef SEQ_TRANSMITTER_STUFF_EN
            r_run   <= w_run_nxt;
            r_tcnt  <= w_tcnt_nxt;
`endif
        end
    end

    // Next-state logic also computes the next values of the registered
    // outputs, so data/busy/done leave the flops with no output decode.
    always_comb begin
        w_state_nxt = r_state;
        w_pat_nxt   = r_pat;
        w_idx_nxt   = r_idx;
        w_data_nxt  = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
`ifdef SEQ_TRANSMITTER_STUFF_EN
        w_tcnt_nxt  = r_tcnt;
`endif

        case (r_state)
            S_IDLE: begin
                if (load) begin
                    w_state_nxt = S_SEND;
                    w_pat_nxt   = pattern;
                    w_idx_nxt   = len;
                    w_data_nxt  = pattern[len];
                    w_busy_nxt  = 1'b1;
`ifndef SEQ_TRANSMITTER_STUFF_EN
                    w_done_nxt  = (len == '0);
`endif
                end
            end

`ifdef SEQ_TRANSMITTER_STUFF_EN
            S_SEND: begin
                w_busy_nxt = 1'b1;
                if (r_idx == '0) begin
                    // A trailing 1 needs a 0 separator so the trailer stays
                    // the only place three 1s can line up.
                    if (r_data) begin
                        w_state_nxt = S_PAD;
                        w_data_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = S_TRAIL;
                        w_data_nxt  = 1'b1;
                        w_tcnt_nxt  = 2'd0;
                    end
                end else if (r_run == 2'd2) begin
                    // Break the run; the pending payload bit waits a cycle.
                    w_state_nxt = S_STUFF;
                    w_data_nxt  = 1'b0;
                end else begin
                    w_idx_nxt   = w_idx_dec;
                    w_data_nxt  = r_pat[w_idx_dec];
                end
            end

            S_STUFF: begin
                w_state_nxt = S_SEND;
                w_idx_nxt   = w_idx_dec;
                w_data_nxt  = r_pat[w_idx_dec];
                w_busy_nxt  = 1'b1;
            end

            S_PAD: begin
                w_state_nxt = S_TRAIL;
                w_data_nxt  = 1'b1;
                w_busy_nxt  = 1'b1;
                w_tcnt_nxt  = 2'd0;
            end

            S_TRAIL: begin
                if (r_tcnt == 2'd2) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_tcnt_nxt  = r_tcnt + 2'd1;
                    w_data_nxt  = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_done_nxt  = (r_tcnt == 2'd1);
                end
            end
`else
            S_SEND: begin
                if (r_idx == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_idx_nxt   = w_idx_dec;
                    w_data_nxt  = r_pat[w_idx_dec];
                    w_busy_nxt  = 1'b1;
                    w_done_nxt  = (r_idx == c_IW'(1));
                end
            end
`endif

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef SEQ_TRANSMITTER_STUFF_EN
    // Saturates at 3 so the trailer cannot wrap the counter back to 0.
    always_comb begin
        w_run_nxt = 2'd0;
        if (w_data_nxt) begin
            w_run_nxt = (r_run == 2'd3) ? 2'd3 : r_run + 2'd1;
        end
    end
`endif

    assign data = r_data;
    assign busy = r_busy;
    assign done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_seq_transmitter.sv
`default_nettype none

module tb_seq_transmitter;

    localparam int NBITS = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [7:0] pattern;
    logic [2:0] len;
    logic       data;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    // expected per-cycle data and done of the current frame
    bit exp_d[$];
    bit exp_done[$];
    // two most recent data samples, feeding a Mealy 111 detector
    logic h1;
    logic h2;

    seq_transmitter #(.NBITS(NBITS)) dut (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .pattern (pattern),
        .len     (len),
        .data    (data),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Frame as the line should show it, built straight from the framing rules.
    task automatic build(input logic [7:0] p, input int l);
        int  run;
        bit  b;
        exp_d.delete();
        exp_done.delete();
        run = 0;
        for (int i = l; i >= 0; i--) begin
            b = p[i];
`ifdef SEQ_TRANSMITTER_STUFF_EN
            if (run == 2) begin
                exp_d.push_back(1'b0);
                run = 0;
            end
`endif
            exp_d.push_back(b);
            run = b ? run + 1 : 0;
        end
`ifdef SEQ_TRANSMITTER_STUFF_EN
        if (p[0]) exp_d.push_back(1'b0);
        repeat (3) exp_d.push_back(1'b1);
`endif
        for (int i = 0; i < exp_d.size(); i++)
            exp_done.push_back(i == exp_d.size() - 1);
    endtask

    task automatic check_cycle(input string tag, input logic ed, input logic eb, input logic edn);
        check({tag, "_data"}, data, ed);
        check({tag, "_busy"}, busy, eb);
        check({tag, "_done"}, done, edn);
`ifdef SEQ_TRANSMITTER_STUFF_EN
        check({tag, "_det111"}, data & h1 & h2, edn);
`endif
        h2 = h1;
        h1 = data;
    endtask

    // inj: cycle during which load is raised again (0 = never)
    // abort_at: cycle during which reset is pulsed (0 = never)
    task automatic run_frame(input logic [7:0] p, input int l, input int inj,
                             input int abort_at, input string tag);
        build(p, l);
        h1 = 1'b0;
        h2 = 1'b0;
        pattern = p;
        len     = 3'(l);
        load    = 1'b1;
        for (int k = 1; k <= exp_d.size(); k++) begin
            tick();
            load    = 1'b0;
            pattern = 8'($urandom);
            len     = 3'($urandom);
            check_cycle($sformatf("%s_c%0d", tag, k), exp_d[k-1], 1'b1, exp_done[k-1]);
            if (k == abort_at) begin
                #2 reset = 1'b0;
                #1;
                check({tag, "_abort_data"}, data, 1'b0);
                check({tag, "_abort_busy"}, busy, 1'b0);
                check({tag, "_abort_done"}, done, 1'b0);
                #2 reset = 1'b1;
                return;
            end
            if (k == inj) begin
                load    = 1'b1;
                pattern = 8'h00;
            end
        end
        tick();
        load = 1'b0;
        check_cycle({tag, "_idle"}, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset   = 1'b0;
        load    = 1'b0;
        pattern = 8'h00;
        len     = 3'd0;
        h1      = 1'b0;
        h2      = 1'b0;

        repeat (2) tick();
        check("reset_data", data, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        #2 reset = 1'b1;
        tick();
        check_cycle("post_reset", 1'b0, 1'b0, 1'b0);

        run_frame(8'hA5, 7, 0, 0, "a5");
        run_frame(8'hFF, 7, 0, 0, "ff");
        run_frame(8'h02, 1, 0, 0, "h02");
        run_frame(8'h01, 0, 0, 0, "len0");
        run_frame(8'hF0, 3, 0, 0, "upper_ignored");
        run_frame(8'hA5, 7, 3, 0, "load_busy");
        run_frame(8'hC3, 7, 0, 4, "abort");
        run_frame(8'h96, 5, 0, 0, "after_abort");

        for (int n = 0; n < 30; n++) begin
            logic [7:0] p;
            int         l;
            int         inj;
            p   = 8'($urandom);
            l   = $urandom_range(0, 7);
            inj = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            run_frame(p, l, inj, 0, $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
